// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester-side and UART-side handshake signals of
//   uart_tx_arbiter, plus the status outputs.
//
//   Handshake rule (all channels): a byte moves only in a cycle where its
//   valid and ready are both high. valid may be presented without ready and
//   is held by the producer until accepted.
//
//   Signals
//     req_valid [N]    requester i has a byte            (requesters -> arbiter)
//     req_data  [8N]   byte of requester i at [8i+7:8i]  (requesters -> arbiter)
//     req_last  [N]    byte is the last of the packet    (requesters -> arbiter)
//     req_ready [N]    arbiter accepts requester i byte  (arbiter -> requesters)
//     tx_valid         byte valid toward UART            (arbiter -> UART)
//     tx_data   [8]    byte toward UART                  (arbiter -> UART)
//     tx_ready         UART accepts a byte               (UART -> arbiter)
//     grant_id  [4]    current / last granted requester  (arbiter status)
//     busy             arbiter is not idle               (arbiter status)
//     dbg_state [2]    raw FSM state, for observation     (arbiter status)
//
//   Modports: slave = arbiter side, master = environment side.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    logic [3:0]     grant_id;
    logic           busy;
    logic [1:0]     dbg_state;

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, grant_id, busy, dbg_state
    );

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, grant_id, busy, dbg_state
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter that funnels byte packets from N requesters into a
//   single UART transmit channel. A grant lasts until the requester's last
//   byte or until MAX_LEN bytes have been sent, whichever comes first; the
//   arbiter then spends at least one cycle idle and resumes the search at the
//   requester after the one just served.
//
//   Optional feature: define UART_TX_TAG_EN to emit a tag byte 8'hF0|g ahead
//   of each grant's data (the tag is not counted toward MAX_LEN).
//
//   Parameters
//     N        number of requesters (2..16)
//     MAX_LEN  bytes per grant before forced release (1..255)
//
//   Ports
//     clk      sole clock, rising edge
//     reset    asynchronous, active-low reset
//     bus      uart_tx_arbiter_if.slave (request, transmit and status signals)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int MAX_LEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1
`ifdef UART_TX_TAG_EN
        ,
        ST_TAG  = 2'd2
`endif
    } state_t;

    localparam logic [7:0] MAX_LEN_C = 8'(MAX_LEN);
    localparam logic [3:0] LAST_IDX  = 4'(N - 1);

    state_t     state_q, state_d;
    logic [3:0] ptr_q, ptr_d;
    logic [3:0] grant_q, grant_d;
    logic [7:0] count_q, count_d;

    // Request vectors widened to 16 entries so the 4-bit grant index always
    // selects in range; entries at or above N read as idle.
    logic [15:0] valid_ext;
    logic [15:0] last_ext;
    logic [7:0]  data_ext [16];

    logic        pick_found;
    logic [3:0]  pick_idx;
    logic [4:0]  scan_idx;
    logic        g_valid;
    logic        g_last;
    logic [3:0]  next_ptr;

    always_comb begin
        valid_ext = 16'(bus.req_valid);
        last_ext  = 16'(bus.req_last);
        for (int i = 0; i < 16; i++) begin
            data_ext[i] = 8'h00;
        end
        for (int i = 0; i < N; i++) begin
            data_ext[i] = bus.req_data[8*i +: 8];
        end
    end

    // Round-robin search starting at ptr. Scanning from the farthest offset
    // down to offset 0 lets the closest valid requester overwrite the others.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 4'd0;
        scan_idx   = 5'd0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_idx = 5'(ptr_q) + 5'(k);
            if (scan_idx >= 5'(N)) begin
                scan_idx = scan_idx - 5'(N);
            end
            if (valid_ext[scan_idx[3:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[3:0];
            end
        end
    end

    assign g_valid  = valid_ext[grant_q];
    assign g_last   = last_ext[grant_q];
    assign next_ptr = (grant_q == LAST_IDX) ? 4'd0 : grant_q + 4'd1;

    // Next-state logic. tx_ready low freezes every register in every state,
    // including the arbitration decision in IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        count_d = count_q;
        if (bus.tx_ready) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_d = pick_idx;
                        count_d = 8'd0;
`ifdef UART_TX_TAG_EN
                        state_d = ST_TAG;
`else
                        state_d = ST_DATA;
`endif
                    end
                end
`ifdef UART_TX_TAG_EN
                ST_TAG: begin
                    state_d = ST_DATA;
                end
`endif
                ST_DATA: begin
                    if (g_valid) begin
                        count_d = count_q + 8'd1;
                        // Release on the packet's last byte or when this byte
                        // reaches the per-grant limit.
                        if (g_last || (count_q + 8'd1 == MAX_LEN_C)) begin
                            state_d = ST_IDLE;
                            ptr_d   = next_ptr;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 4'd0;
            grant_q <= 4'd0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            count_q <= count_d;
        end
    end

    // The data path is a combinational window onto the granted requester, so
    // backpressure reaches the requester in the same cycle.
    always_comb begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        unique case (state_q)
`ifdef UART_TX_TAG_EN
            ST_TAG: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = 8'hF0 | {4'h0, grant_q};
            end
`endif
            ST_DATA: begin
                bus.tx_valid = g_valid;
                bus.tx_data  = data_ext[grant_q];
            end
            default: begin
                bus.tx_valid = 1'b0;
                bus.tx_data  = 8'h00;
            end
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_ready[i] = (state_q == ST_DATA) && (grant_q == 4'(i)) && bus.tx_ready;
        end
    end

    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.dbg_state = state_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (legal range 2..16).
REQ-002 SHALL have parameter MAX_LEN, default 64, maximum bytes per grant before forced release (legal range 1..255).
REQ-003 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, N: per-requester byte valid.
REQ-006 SHALL have port req_data, input, 8*N: byte for requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_last, input, N: marks the final byte of requester i's packet.
REQ-008 SHALL have port req_ready, output, N: per-requester byte accept.
REQ-009 SHALL have port tx_valid, output, 1: byte valid toward the UART transmit channel.
REQ-010 SHALL have port tx_data, output, 8: byte toward the UART transmit channel.
REQ-011 SHALL have port tx_ready, input, 1: UART transmit channel can accept a byte.
REQ-012 SHALL have port grant_id, output, 4: index of the current or last granted requester.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 SHALL transfer a byte on any interface only in a cycle where its valid and ready are both high.
REQ-015 SHALL implement states IDLE, TAG and DATA; TAG exists only per REQ-031.
REQ-016 In IDLE, SHALL select the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo N.
REQ-017 On selection, SHALL register grant_id=i, clear the byte count, and enter TAG (or DATA) on the next edge; this gives one cycle of arbitration latency.
REQ-018 In IDLE, SHALL drive tx_valid=0 and req_ready=0.
REQ-019 In DATA, SHALL drive combinationally: tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready; every other req_ready SHALL be 0.
REQ-020 In DATA, each transfer SHALL increment the byte count (width 8 bits, no wrap, since count<=MAX_LEN).
REQ-021 A transfer with req_last[g]=1 SHALL return the arbiter to IDLE and set ptr=(g+1) mod N.
REQ-022 A transfer that makes count equal to MAX_LEN with req_last[g]=0 SHALL force release: IDLE, ptr=(g+1) mod N.
REQ-023 req_valid[g] deasserting mid-packet SHALL hold the grant with tx_valid=0 and no timeout.
REQ-024 Requests arriving while busy SHALL wait; req_valid of non-granted requesters SHALL NOT affect outputs.
REQ-025 In any state, tx_ready=0 SHALL stall with all state held.
REQ-026 After release, SHALL return to IDLE for at least one cycle, even if other requests are pending.
REQ-027 grant_id SHALL hold its value in IDLE.

Reset
REQ-028 Asserting reset (low) SHALL immediately force IDLE, ptr=0, grant_id=0, count=0, tx_valid=0, req_ready=0, busy=0, tx_data=0.
REQ-029 Reset mid-packet SHALL abandon the packet; the first grant after reset SHALL start from ptr=0.
REQ-030 Reset release SHALL take effect synchronously; the first arbitration occurs on the first edge with reset high.

Configuration
REQ-031 With UART_TX_TAG_EN defined, selection SHALL enter TAG, driving tx_valid=1, tx_data=8'hF0|g, and req_ready=0; TAG SHALL go to DATA on tx_ready=1, and the tag byte SHALL NOT count toward MAX_LEN.
REQ-032 With UART_TX_TAG_EN undefined, selection SHALL go directly to DATA, TAG logic SHALL be absent, and no tag bytes SHALL be emitted.

Verification
REQ-033 Bench SHALL cover: after reset, req 2 sends 3 bytes 11,22,33 (last on 33), tx_ready=1 -> tx sees 11,22,33 (tagged build: F2 first); grant_id=2; busy falls after 33.
REQ-034 Bench SHALL cover: req 0 and req 1 valid together, ptr=0 -> req 0 packet completes fully before req 1; next simultaneous request goes to req 1 first.
REQ-035 Bench SHALL cover: MAX_LEN=4, req 3 streams 10 bytes with no last while req 0 is pending -> 4 bytes from req 3, then req 0's packet, then req 3 resumes.
REQ-036 Bench SHALL cover: tx_ready toggling 1,0,0,1 during a packet -> no byte duplicated or lost; req_ready[g] mirrors tx_ready.
REQ-037 Bench SHALL cover: reset pulsed low mid-packet -> outputs zero in the same cycle; afterwards req 1 and req 2 both valid -> req 1 granted.
